turn_signal_conditioner: RTL and testbench
==========================================

TURN_SIGNAL_CONDITIONER -- requirements
Module: turn_signal_conditioner

Interface
REQ-001 Parameter DB_COUNT, default 4: consecutive stable synchronized samples required before a debounced input changes; legal range 1..255.
REQ-002 Parameter TICK_DIV, default 8: clock cycles per step tick; legal range 2..65535.
REQ-003 Parameter MAX_STEPS, default 16: watchdog limit on step ticks per sequence; legal range 1..255.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 left_raw  input  1  raw left turn switch, asynchronous to clk, may bounce.
REQ-007 right_raw  input  1  raw right turn switch, asynchronous to clk, may bounce.
REQ-008 seq_done  input  1  one-cycle pulse from the downstream tail-light sequencer when it returns to its off state.
REQ-009 left  output  1  latched left request to the sequencer.
REQ-010 right  output  1  latched right request to the sequencer; left=right=1 means hazard.
REQ-011 step  output  1  one-cycle enable pulse that advances the sequencer by one state.
REQ-012 busy  output  1  high while a sequence is in progress (state ACTIVE).
REQ-013 fault  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-014 Each raw input SHALL pass through a two-flop synchronizer (sync1, sync2) before any other logic.
REQ-015 Debounce, per channel: sync2 == db -> counter cleared; sync2 != db and counter == DB_COUNT-1 -> db <= sync2, counter cleared; otherwise counter increments.
REQ-016 Debounce latency: raw value first captured by sync1 at edge N and held stable -> db changes at edge N+1+DB_COUNT; any reversion before then SHALL leave db unchanged and clear the counter.
REQ-017 Control FSM states: IDLE, ACTIVE; encoding free; no other reachable states.
REQ-018 IDLE: left=right=busy=step=0; prescaler and step counter held at 0; if db_left|db_right -> next edge left<=db_left, right<=db_right, state ACTIVE.
REQ-019 Both debounced requests rising on the same edge SHALL be captured together (hazard); a second request rising while ACTIVE SHALL be ignored until the next capture.
REQ-020 ACTIVE: left/right SHALL hold their captured values regardless of the switches (a sequence always completes), busy=1.
REQ-021 Prescaler in ACTIVE: counts 0..TICK_DIV-1 and wraps; step=1 combinationally when count == TICK_DIV-1 in ACTIVE; first step occurs TICK_DIV cycles after entering ACTIVE.
REQ-022 ACTIVE and seq_done=1 -> next edge: state IDLE, left=right=0, prescaler and step counter cleared; step suppressed from that edge on.
REQ-023 A request present in the cycle seq_done is seen SHALL NOT be captured that cycle; capture occurs no earlier than the following cycle from IDLE (minimum one IDLE cycle between sequences).
REQ-024 Step counter increments on each step in ACTIVE; step emitted while counter == MAX_STEPS-1 and no seq_done -> fault=1 on the next cycle, state IDLE, outputs cleared, as in REQ-022.
REQ-025 seq_done in IDLE SHALL be ignored.
REQ-026 Counter widths SHALL be sized from the parameters; no counter SHALL overflow or wrap except the prescaler per REQ-021.

Reset
REQ-027 reset=1 at an edge: sync flops, db values, debounce counters, prescaler, and step counter = 0; state IDLE; left=right=step=busy=fault=0.
REQ-028 Reset mid-sequence SHALL abort immediately; no step or fault pulse in the cycle after reset deasserts; raw inputs held high afterward re-qualify through the full REQ-016 latency.

Verification (DB_COUNT=4, TICK_DIV=8, MAX_STEPS=16)
REQ-029 left_raw 0->1 sampled at edge 0, held -> db_left at edge 5, left=1 and busy=1 at edge 6, steps at cycles 13, 21, 29; right stays 0.
REQ-030 left_raw bounces 1,0,1,0 on alternating cycles then returns to 0 -> left, busy, step stay 0 throughout.
REQ-031 left_raw and right_raw rise on the same edge -> left=right=1 on the same edge; right_raw released mid-sequence -> right stays 1 until seq_done.
REQ-032 seq_done pulsed with left_raw still high -> outputs 0 for exactly one cycle, then recaptured; prescaler restarts, first step 8 cycles later.
REQ-033 seq_done never asserted -> exactly 16 step pulses, then fault one-cycle pulse, busy=0, left=0.
REQ-034 reset asserted for one cycle during ACTIVE between steps -> all outputs 0 next cycle; with left_raw still high, left returns no earlier than 7 cycles after reset deasserts.

Source files
------------

// File: rtl/turn_signal_conditioner.sv
// Turn signal conditioner: synchronizes and debounces the raw left/right turn
// switches, latches a request (left, right or hazard) and paces a downstream
// tail-light sequencer with periodic step pulses until it reports completion.
// A watchdog aborts a sequence that never completes.
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous active-high reset
//   left_raw   raw left switch (asynchronous, may bounce)
//   right_raw  raw right switch (asynchronous, may bounce)
//   seq_done   one-cycle pulse from the sequencer when it returns to off
//   left       latched left request
//   right      latched right request (left & right = hazard)
//   step       one-cycle advance pulse for the sequencer
//   busy       high while a sequence is in progress
//   fault      one-cycle pulse when the watchdog expires
//
// States:
//   IDLE   | no sequence; waiting for a debounced request
//   ACTIVE | request latched; prescaler generating steps until done/watchdog
module turn_signal_conditioner #(
  parameter int DB_COUNT  = 4,
  parameter int TICK_DIV  = 8,
  parameter int MAX_STEPS = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic left_raw,
  input  logic right_raw,
  input  logic seq_done,
  output logic left,
  output logic right,
  output logic step,
  output logic busy,
  output logic fault
);

  localparam int DBW = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
  localparam int PSW = $clog2(TICK_DIV);
  localparam int SCW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_COUNT - 1);
  localparam logic [PSW-1:0] PS_LAST = PSW'(TICK_DIV - 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(MAX_STEPS - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Bit 0 = left channel, bit 1 = right channel.
  logic [1:0]          sync1;
  logic [1:0]          sync2;
  logic [1:0]          db;
  logic [1:0][DBW-1:0] db_cnt;

  state_t         state, state_nxt;
  logic [PSW-1:0] presc, presc_nxt;
  logic [SCW-1:0] scnt, scnt_nxt;
  logic           left_nxt, right_nxt, fault_nxt;

  // Synchronizers and per-channel debounce. A changed value must be seen for
  // DB_COUNT consecutive edges; any reversion clears the run.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      db     <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= {right_raw, left_raw};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      presc <= '0;
      scnt  <= '0;
      left  <= 1'b0;
      right <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= state_nxt;
      presc <= presc_nxt;
      scnt  <= scnt_nxt;
      left  <= left_nxt;
      right <= right_nxt;
      fault <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    presc_nxt = '0;
    scnt_nxt  = '0;
    left_nxt  = 1'b0;
    right_nxt = 1'b0;
    fault_nxt = 1'b0;
    step      = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        // seq_done is meaningless here and deliberately not looked at.
        if (db[0] | db[1]) begin
          state_nxt = ACTIVE;
          left_nxt  = db[0];
          right_nxt = db[1];
        end
      end
      ACTIVE: begin
        busy      = 1'b1;
        step      = (presc == PS_LAST);
        left_nxt  = left;
        right_nxt = right;
        presc_nxt = step ? '0 : presc + PSW'(1);
        scnt_nxt  = scnt;
        // Completion wins over a coincident watchdog expiry. Both exits clear
        // the step counter before its increment could wrap.
        if (seq_done) begin
          state_nxt = IDLE;
          left_nxt  = 1'b0;
          right_nxt = 1'b0;
          presc_nxt = '0;
          scnt_nxt  = '0;
        end else if (step && (scnt == SC_LAST)) begin
          state_nxt = IDLE;
          left_nxt  = 1'b0;
          right_nxt = 1'b0;
          presc_nxt = '0;
          scnt_nxt  = '0;
          fault_nxt = 1'b1;
        end else if (step) begin
          scnt_nxt = scnt + SCW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_turn_signal_conditioner.sv
module tb_turn_signal_conditioner;
  localparam int DB = 4;
  localparam int TD = 8;
  localparam int MS = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic left_raw = 1'b0;
  logic right_raw = 1'b0;
  logic seq_done = 1'b0;
  logic left, right, step, busy, fault;

  turn_signal_conditioner #(.DB_COUNT(DB), .TICK_DIV(TD), .MAX_STEPS(MS)) dut (
    .clk(clk), .reset(reset), .left_raw(left_raw), .right_raw(right_raw),
    .seq_done(seq_done), .left(left), .right(right), .step(step),
    .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit started = 1'b0;

  // Behavioural model: raw samples flow through a two-deep pipe; a debounced
  // value flips when the last DB pipe outputs all disagree with it. A sequence
  // is tracked as elapsed time t since capture: step whenever t mod TD is TD-1,
  // watchdog when the step number (t+1)/TD reaches MS.
  bit m_s1l, m_s2l, m_s1r, m_s2r, m_dbl, m_dbr;
  bit hl[DB];
  bit hr[DB];
  bit fl, fr;
  bit m_active, m_left, m_right, m_fault;
  int m_t;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      started = 1'b1;
      m_s1l = 0; m_s2l = 0; m_s1r = 0; m_s2r = 0;
      m_dbl = 0; m_dbr = 0;
      for (int i = 0; i < DB; i++) begin
        hl[i] = 0;
        hr[i] = 0;
      end
      m_active = 0; m_left = 0; m_right = 0; m_fault = 0; m_t = 0;
    end else begin
      m_fault = 0;
      if (m_active) begin
        if (seq_done) begin
          m_active = 0; m_left = 0; m_right = 0;
        end else if ((m_t % TD == TD - 1) && ((m_t + 1) / TD == MS)) begin
          m_active = 0; m_left = 0; m_right = 0; m_fault = 1;
        end else begin
          m_t++;
        end
      end else if (m_dbl || m_dbr) begin
        m_active = 1; m_t = 0; m_left = m_dbl; m_right = m_dbr;
      end
      for (int i = DB - 1; i > 0; i--) begin
        hl[i] = hl[i-1];
        hr[i] = hr[i-1];
      end
      hl[0] = m_s2l;
      hr[0] = m_s2r;
      fl = 1; fr = 1;
      for (int i = 0; i < DB; i++) begin
        if (hl[i] == m_dbl) fl = 0;
        if (hr[i] == m_dbr) fr = 0;
      end
      if (fl) m_dbl = !m_dbl;
      if (fr) m_dbr = !m_dbr;
      m_s2l = m_s1l; m_s1l = left_raw;
      m_s2r = m_s1r; m_s1r = right_raw;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("left", left, m_left);
      check("right", right, m_right);
      check("busy", busy, m_active);
      check("step", step, m_active && (m_t % TD == TD - 1));
      check("fault", fault, m_fault);
    end
  end

  // After this returns, cyc is the edge just taken and outputs reflect it;
  // inputs written now are sampled at edge cyc+1.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic finish_seq();
    left_raw = 0;
    right_raw = 0;
    repeat (8) tick();
    seq_done = 1;
    tick();
    seq_done = 0;
    repeat (4) tick();
    check("idle_after_done", busy, 1'b0);
  endtask

  int e0, s0, r0, first_left, first_right, first_busy, first_step, nsteps, bad_cnt;
  int stp[$];
  logic lv[12];
  bit got_fault;

  initial begin
    repeat (3) tick();
    check("reset_left", left, 1'b0);
    check("reset_busy", busy, 1'b0);
    reset = 0;
    repeat (2) tick();

    // Single left request: capture latency and step cadence.
    left_raw = 1;
    e0 = cyc + 1;
    first_left = -1; first_busy = -1; bad_cnt = 0;
    stp.delete();
    repeat (30) begin
      tick();
      if (left && first_left < 0) first_left = cyc - e0;
      if (busy && first_busy < 0) first_busy = cyc - e0;
      if (step) stp.push_back(cyc - e0);
      if (right) bad_cnt++;
    end
    check_int("left_latency", first_left, 6);
    check_int("busy_latency", first_busy, 6);
    check_int("step_count_30", stp.size(), 3);
    check_int("step1_at", (stp.size() > 0) ? stp[0] : -1, 13);
    check_int("step2_at", (stp.size() > 1) ? stp[1] : -1, 21);
    check_int("step3_at", (stp.size() > 2) ? stp[2] : -1, 29);
    check_int("right_stays_low", bad_cnt, 0);
    finish_seq();

    // Bouncing switch never qualifies.
    bad_cnt = 0;
    left_raw = 1; tick();
    left_raw = 0; tick();
    left_raw = 1; tick();
    left_raw = 0; tick();
    repeat (20) begin
      tick();
      if (left || busy || step) bad_cnt++;
    end
    check_int("bounce_ignored", bad_cnt, 0);

    // seq_done while idle does nothing.
    seq_done = 1; tick();
    seq_done = 0;
    repeat (3) tick();
    check("done_in_idle", busy, 1'b0);

    // Hazard: both captured together; right held after its switch opens.
    left_raw = 1; right_raw = 1;
    e0 = cyc + 1;
    first_left = -1; first_right = -1;
    repeat (12) begin
      tick();
      if (left && first_left < 0) first_left = cyc - e0;
      if (right && first_right < 0) first_right = cyc - e0;
    end
    check_int("hazard_left_at", first_left, 6);
    check_int("hazard_right_at", first_right, 6);
    right_raw = 0;
    bad_cnt = 0;
    repeat (20) begin
      tick();
      if (!right) bad_cnt++;
    end
    check_int("hazard_right_held", bad_cnt, 0);
    finish_seq();

    // Done with switch still on: one idle cycle, recapture, fresh prescaler.
    left_raw = 1;
    repeat (16) tick();
    check("pre_done_left", left, 1'b1);
    seq_done = 1;
    s0 = cyc + 1;
    tick();
    seq_done = 0;
    lv[0] = left;
    first_step = step ? 0 : -1;
    for (int k = 1; k < 12; k++) begin
      tick();
      lv[k] = left;
      if (step && first_step < 0) first_step = cyc - s0;
    end
    check("redo_gap_left", lv[0], 1'b0);
    check("redo_recapture", lv[1], 1'b1);
    check_int("redo_first_step", first_step, 8);
    finish_seq();

    // Watchdog: sequencer never answers.
    left_raw = 1;
    nsteps = 0; got_fault = 0;
    for (int k = 0; k < 200 && !got_fault; k++) begin
      tick();
      if (k == 20) left_raw = 0;
      if (step) nsteps++;
      if (fault) begin
        got_fault = 1;
        check("wd_busy_cleared", busy, 1'b0);
        check("wd_left_cleared", left, 1'b0);
      end
    end
    check("wd_fault_seen", got_fault, 1'b1);
    check_int("wd_step_count", nsteps, 16);
    tick();
    check("wd_fault_one_cycle", fault, 1'b0);
    repeat (4) tick();

    // Reset mid-sequence between steps, switch still on.
    left_raw = 1;
    repeat (20) tick();
    check("pre_reset_busy", busy, 1'b1);
    reset = 1;
    r0 = cyc + 1;
    tick();
    reset = 0;
    check("rst_left", left, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_step", step, 1'b0);
    check("rst_fault", fault, 1'b0);
    first_left = -1;
    repeat (15) begin
      tick();
      if (left && first_left < 0) first_left = cyc - r0;
    end
    check_int("rst_requalify", first_left, 7);
    finish_seq();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
